// File: rtl/change_dispenser_if.sv
// Bundle between the vending-machine state stage and the change dispenser.
// The master side supplies the registered total and user events; the slave
// side (the dispenser) reports coins paid, completion and the idle counter.
interface change_dispenser_if #(
   parameter int TOTAL_BITS = 31,
   parameter int WAIT_BITS  = 8
);
   logic [TOTAL_BITS-1:0] i_total;
   logic                  i_activity;
   logic                  i_return_req;
   logic [2:0]            o_return_coin;
   logic [TOTAL_BITS-1:0] o_dec_amount;
   logic                  o_busy;
   logic                  o_done;
   logic [TOTAL_BITS-1:0] o_residue;
   logic [WAIT_BITS-1:0]  o_wait_count;

   modport master (
      output i_total, i_activity, i_return_req,
      input  o_return_coin, o_dec_amount, o_busy, o_done, o_residue, o_wait_count
   );

   modport slave (
      input  i_total, i_activity, i_return_req,
      output o_return_coin, o_dec_amount, o_busy, o_done, o_residue, o_wait_count
   );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: on a return request or idle timeout it snapshots the
// current total and pays it out greedily, one coin per cycle, largest coin
// first. All outputs are decoded from registered state only.
module change_dispenser #(
   parameter int TOTAL_BITS = 31,
   parameter int COIN0_VAL  = 100,
   parameter int COIN1_VAL  = 500,
   parameter int COIN2_VAL  = 1000,
   parameter int WAIT_TIME  = 100,
   parameter int WAIT_BITS  = 8
) (
   input  logic                clk,
   input  logic                reset,
   change_dispenser_if.slave   bus
);

   localparam logic [TOTAL_BITS-1:0] COIN0 = TOTAL_BITS'(COIN0_VAL);
   localparam logic [TOTAL_BITS-1:0] COIN1 = TOTAL_BITS'(COIN1_VAL);
   localparam logic [TOTAL_BITS-1:0] COIN2 = TOTAL_BITS'(COIN2_VAL);
   localparam logic [WAIT_BITS-1:0]  WAIT_LAST = WAIT_BITS'(WAIT_TIME - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [TOTAL_BITS-1:0] remaining, remaining_next;
   logic [WAIT_BITS-1:0]  wait_count, wait_count_next;
   logic [2:0]            coin_sel;
   logic [TOTAL_BITS-1:0] coin_val;
   logic [TOTAL_BITS-1:0] remaining_after;
   logic                  trigger;

   // Largest coin that still fits in the amount left; zero when none fits.
   function automatic logic [2:0] pick_coin(input logic [TOTAL_BITS-1:0] amount);
      if (amount >= COIN2)      return 3'b100;
      else if (amount >= COIN1) return 3'b010;
      else if (amount >= COIN0) return 3'b001;
      else                      return 3'b000;
   endfunction

   // Value of a one-hot coin code.
   function automatic logic [TOTAL_BITS-1:0] coin_value(input logic [2:0] coin);
      case (coin)
         3'b100:  return COIN2;
         3'b010:  return COIN1;
         3'b001:  return COIN0;
         default: return '0;
      endcase
   endfunction

   // Coin presented this cycle, decoded from state and the remaining register.
   always_comb begin
      coin_sel = 3'b000;
      if (state == DISPENSE) coin_sel = pick_coin(remaining);
      coin_val        = coin_value(coin_sel);
      remaining_after = remaining - coin_val;
   end

   assign trigger = bus.i_return_req | (wait_count == WAIT_LAST);

   // Register update for state, payout amount and idle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         remaining  <= '0;
         wait_count <= '0;
      end else begin
         state      <= state_next;
         remaining  <= remaining_next;
         wait_count <= wait_count_next;
      end
   end

   // Next-state logic. The last coin of a payout moves straight to DONE so
   // o_done follows it immediately; an unpayable start spends one empty
   // DISPENSE cycle first.
   always_comb begin
      state_next      = state;
      remaining_next  = remaining;
      wait_count_next = wait_count;
      case (state)
         IDLE: begin
            if (trigger) begin
               remaining_next  = bus.i_total;
               wait_count_next = '0;
               state_next      = DISPENSE;
            end else if (bus.i_activity) begin
               wait_count_next = '0;
            end else begin
               wait_count_next = wait_count + 1'b1;
            end
         end
         DISPENSE: begin
            wait_count_next = '0;
            if (coin_sel != 3'b000) begin
               remaining_next = remaining_after;
               if (remaining_after < COIN0) state_next = DONE;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            wait_count_next = '0;
            remaining_next  = '0;
            state_next      = IDLE;
         end
         default: begin
            wait_count_next = '0;
            remaining_next  = '0;
            state_next      = IDLE;
         end
      endcase
   end

   assign bus.o_return_coin = coin_sel;
   assign bus.o_dec_amount  = coin_val;
   assign bus.o_busy        = (state != IDLE);
   assign bus.o_done        = (state == DONE);
   assign bus.o_residue     = (state == DONE) ? remaining : '0;
   assign bus.o_wait_count  = wait_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed payouts with a scoreboard queue
// of expected coin/done events checked by an independent monitor.
module tb_change_dispenser;

   localparam int TW = 31;
   localparam int WB = 8;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int            cyc;
      logic [2:0]    coin;
      logic [TW-1:0] dec;
      logic          done;
      logic [TW-1:0] residue;
   } exp_t;

   exp_t exp_q[$];

   change_dispenser_if #(.TOTAL_BITS(TW), .WAIT_BITS(WB)) bus ();

   change_dispenser #(
      .TOTAL_BITS(TW), .COIN0_VAL(100), .COIN1_VAL(500), .COIN2_VAL(1000),
      .WAIT_TIME(100), .WAIT_BITS(WB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock and cycle index.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every coin or done cycle must match the head of the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.o_return_coin != 3'b000 || bus.o_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output cyc=%0d coin=%b dec=%0d done=%b residue=%0d (expected no output)",
                        cyc, bus.o_return_coin, bus.o_dec_amount, bus.o_done, bus.o_residue);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (cyc != e.cyc || bus.o_return_coin != e.coin || bus.o_dec_amount != e.dec ||
                   bus.o_done != e.done || bus.o_residue != e.residue) begin
                  fails++;
                  $display("FAIL payout_event got cyc=%0d coin=%b dec=%0d done=%b res=%0d expected cyc=%0d coin=%b dec=%0d done=%b res=%0d",
                           cyc, bus.o_return_coin, bus.o_dec_amount, bus.o_done, bus.o_residue,
                           e.cyc, e.coin, e.dec, e.done, e.residue);
               end
            end
         end else begin
            checks++;
            if (bus.o_dec_amount != '0) begin
               fails++;
               $display("FAIL idle_dec cyc=%0d got %0d expected 0", cyc, bus.o_dec_amount);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, actual, expected);
      end
   endtask

   task automatic push_coin(input int at, input logic [2:0] coin, input int val);
      exp_t e;
      e.cyc = at; e.coin = coin; e.dec = TW'(val); e.done = 1'b0; e.residue = '0;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int at, input int residue);
      exp_t e;
      e.cyc = at; e.coin = 3'b000; e.dec = '0; e.done = 1'b1; e.residue = TW'(residue);
      exp_q.push_back(e);
   endtask

   initial begin
      int n;
      int m;
      reset             = 1'b1;
      bus.i_total       = '0;
      bus.i_activity    = 1'b0;
      bus.i_return_req  = 1'b0;
      repeat (3) tick();
      mon_en = 1'b1;

      // Reset state
      check("rst_coin",  bus.o_return_coin, 0);
      check("rst_dec",   bus.o_dec_amount, 0);
      check("rst_busy",  bus.o_busy, 0);
      check("rst_done",  bus.o_done, 0);
      check("rst_res",   bus.o_residue, 0);
      check("rst_wait",  bus.o_wait_count, 0);
      reset = 1'b0;
      tick();

      // 1700 -> 1000, 500, 100, 100, done residue 0
      bus.i_total = TW'(1700); bus.i_return_req = 1'b1; n = cyc;
      push_coin(n + 1, 3'b100, 1000);
      push_coin(n + 2, 3'b010, 500);
      push_coin(n + 3, 3'b001, 100);
      push_coin(n + 4, 3'b001, 100);
      push_done(n + 5, 0);
      tick(); bus.i_return_req = 1'b0;
      check("t1_busy", bus.o_busy, 1);
      check("t1_wait", bus.o_wait_count, 0);
      repeat (6) tick();

      // 150 -> one 100 coin, residue 50
      bus.i_total = TW'(150); bus.i_return_req = 1'b1; n = cyc;
      push_coin(n + 1, 3'b001, 100);
      push_done(n + 2, 50);
      tick(); bus.i_return_req = 1'b0;
      repeat (4) tick();

      // 0 -> one empty DISPENSE cycle, done two cycles after trigger
      bus.i_total = '0; bus.i_return_req = 1'b1; n = cyc;
      push_done(n + 2, 0);
      tick(); bus.i_return_req = 1'b0;
      check("t3_busy_empty", bus.o_busy, 1);
      repeat (4) tick();

      // Return and activity together: trigger wins; return during payout ignored
      repeat (10) tick();
      bus.i_total = TW'(1700); bus.i_return_req = 1'b1; bus.i_activity = 1'b1; n = cyc;
      push_coin(n + 1, 3'b100, 1000);
      push_coin(n + 2, 3'b010, 500);
      push_coin(n + 3, 3'b001, 100);
      push_coin(n + 4, 3'b001, 100);
      push_done(n + 5, 0);
      tick(); bus.i_return_req = 1'b0; bus.i_activity = 1'b0;
      check("t6_busy", bus.o_busy, 1);
      check("t6_wait", bus.o_wait_count, 0);
      tick();
      bus.i_return_req = 1'b1; bus.i_total = TW'(2000);
      tick(); bus.i_return_req = 1'b0; bus.i_total = TW'(1700);
      repeat (3) tick();
      check("t6_idle_busy", bus.o_busy, 0);
      check("t6_idle_wait", bus.o_wait_count, 0);
      tick();
      check("t6_wait_inc", bus.o_wait_count, 1);

      // Idle timeout with an activity restart at wait_count 98
      bus.i_total = TW'(500); bus.i_activity = 1'b1;
      tick(); bus.i_activity = 1'b0;
      check("t4_wait0", bus.o_wait_count, 0);
      repeat (98) tick();
      check("t4_wait98", bus.o_wait_count, 98);
      bus.i_activity = 1'b1; m = cyc;
      push_coin(m + 101, 3'b010, 500);
      push_done(m + 102, 0);
      tick(); bus.i_activity = 1'b0;
      check("t4_restart", bus.o_wait_count, 0);
      repeat (99) tick();
      check("t4_wait99", bus.o_wait_count, 99);
      check("t4_not_busy", bus.o_busy, 0);
      tick();
      check("t4_busy", bus.o_busy, 1);
      repeat (3) tick();

      // Reset during the second coin of a 1700 payout
      bus.i_total = TW'(1700); bus.i_return_req = 1'b1; n = cyc;
      push_coin(n + 1, 3'b100, 1000);
      push_coin(n + 2, 3'b010, 500);
      tick(); bus.i_return_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("t5_coin", bus.o_return_coin, 0);
      check("t5_dec",  bus.o_dec_amount, 0);
      check("t5_busy", bus.o_busy, 0);
      check("t5_done", bus.o_done, 0);
      check("t5_res",  bus.o_residue, 0);
      check("t5_wait", bus.o_wait_count, 0);
      reset = 1'b0;
      repeat (8) tick();

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
